param_seq_detector: RTL and testbench
=====================================

// Module: param_seq_detector
// PURPOSE
//  Runtime-programmable serial bit-pattern detector. Generalises the fixed 4-bit "1010" Moore detector.
//  Pattern length is programmable from 2..MAX_W, and overlapping or non-overlapping matching is selectable.
//  Input carries a per-bit valid qualifier, and a saturating match counter is included.
//  Sits on any serial bit stream (framing/sync-word hunt) as a leaf block.
// PARAMETERS
//  MAX_W   8   maximum pattern length in bits; legal range 2..32
//  CNT_W   16  width of match_count; legal range 1..32
// PORTS
//  clk          in   1                    single clock, all state on rising edge
//  reset        in   1                    asynchronous, active-high; clears all state immediately
//  cfg_load     in   1                    latch cfg_* this edge; clears history
//  cfg_pattern  in   MAX_W                pattern, bit [len-1] is first-received bit
//  cfg_len      in   $clog2(MAX_W+1)      pattern length in bits
//  cfg_overlap  in   1                    1 = overlapping matches allowed, 0 = non-overlapping
//  din_valid    in   1                    din is sampled only when high
//  din          in   1                    serial data bit
//  cnt_clr      in   1                    synchronous clear of match_count
//  armed        out  1                    legal config is loaded and detection is active
//  match        out  1                    registered 1-cycle pulse per detected pattern
//  match_count  out  CNT_W                saturating count of matches
// BEHAVIOUR
//  Reset values (async, active-high):
//   - hist=0, fill=0, pat/len/ovl regs=0; armed=0, match=0, match_count=0.
//   - Effect is immediate, including mid-stream; no match is produced until a legal cfg_load.
//  cfg_load:
//   - Latches pattern, len and overlap; clears hist and fill; match<=0.
//   - armed<=1 iff 2<=cfg_len<=MAX_W, else armed<=0 (regs still latched).
//   - din_valid in the same cycle is ignored; cfg_load has priority over data.
//  Data edge (armed & din_valid & !cfg_load):
//   - hist_n = {hist[MAX_W-2:0], din}; fill_n = min(fill+1, len).
//   - hit = (fill_n == len) && (hist_n[len-1:0] == pat[len-1:0]); bits above len are masked off.
//   - hist<=hist_n; match<=hit.
//   - fill<=(hit && !ovl) ? 0 : fill_n. Non-overlap discards bits consumed by the match.
//  Idle edge (!din_valid or !armed): hist and fill hold; match<=0.
//  Latency: match is high for exactly the cycle after the edge that sampled the final pattern bit.
//   - Back-to-back pulses are possible in overlap mode (e.g. pattern 11, stream 111).
//  match_count:
//   - +1 on each edge where hit=1; saturates at 2^CNT_W-1 (no wrap).
//   - cnt_clr clears to 0; if cnt_clr and hit coincide, clear wins (count=0) but the match pulse still occurs.
//  Example: pattern 4'b1010, len 4, overlap 1.
//   - Stream 1,0,1,0,1,0 -> pulses after bits 4 and 6.
//   - Same stream with overlap 0 -> pulse after bit 4 only.
// STRUCTURE
//  Package seq_det_pkg:
//   - MAX_W_LIMIT=32, MIN_LEN=2 constants.
//   - function len_legal(len, max_w) returning bit.
//   - function len_mask(len) returning the MAX_W-bit compare mask.
//  Sub-module seq_sat_counter #(CNT_W) (clk, reset, clr, inc, count):
//   - Saturating counter with clear priority.
//  Top holds config regs, hist shift register, fill counter and compare/match register.
// TESTING
//  T1: reset; load 1010/len4/ovl1; din 1,0,1,0,1,0 valid every cycle
//      -> match pulses 1 cycle after bits 4 and 6; count=2.
//  T2: same load with ovl0; streams 101010 and 10101010
//      -> 1 and 2 pulses respectively; count=3 total.
//  T3: din_valid gaps: 1,0,(3 idle cycles),1,0
//      -> single pulse 1 cycle after final valid bit; no pulse during idles.
//  T4: cfg_load issued after 1,0,1 then din 0
//      -> no match (history cleared); cfg_len=1 or MAX_W+1 -> armed=0, no matches.
//  T5: CNT_W=4, 17 matches -> count 15 held; cnt_clr on a hit edge
//      -> count 0, match still pulses.
//  T6: assert reset between edges mid-stream
//      -> armed/match/count 0 before next edge; no match until reload.
//  Sweep MAX_W in {2,8,32}; random stream vs. reference model comparing match and count.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int unsigned MAX_W_LIMIT = 32;
    localparam int unsigned MIN_LEN     = 2;

    // A length is usable only if it is at least MIN_LEN and fits the history register.
    function automatic bit len_legal(input int unsigned len, input int unsigned max_w);
        return (len >= MIN_LEN) && (len <= max_w);
    endfunction

    // Mask with the low 'len' bits set; callers truncate it to their own history width.
    function automatic logic [MAX_W_LIMIT-1:0] len_mask(input int unsigned len);
        logic [MAX_W_LIMIT-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W_LIMIT; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter; a synchronous clear beats a simultaneous increment.
module seq_sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// per-bit valid qualifier and a saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_load,
    input  logic [MAX_W-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         din_valid,
    input  logic                         din,
    input  logic                         cnt_clr,
    output logic                         armed,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count
);

    localparam int unsigned LEN_W = $clog2(MAX_W + 1);

    // Latched configuration
    logic [MAX_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic             armed_q;

    // Detection state
    logic [MAX_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic             match_q;

    // Next-state terms for a data edge
    logic             data_edge;
    logic [MAX_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [MAX_W-1:0] cmp_mask;
    logic             window_eq;
    logic             hit;

    // Compute the shifted history, fill level and hit decision for this edge.
    always_comb begin
        data_edge = armed_q & din_valid & ~cfg_load;
        // Shifting the whole register drops the oldest bit; newest bit lands at [0].
        hist_n    = (hist_q << 1) | MAX_W'(din);
        fill_n    = (fill_q >= len_q) ? len_q : (fill_q + LEN_W'(1));
        cmp_mask  = MAX_W'(len_mask(32'(len_q)));
        window_eq = (((hist_n ^ pat_q) & cmp_mask) == '0);
        hit       = data_edge && (fill_n == len_q) && window_eq;
    end

    // Configuration registers; armed only for a legal length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            armed_q <= 1'b0;
        end else if (cfg_load) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            ovl_q   <= cfg_overlap;
            armed_q <= len_legal(32'(cfg_len), MAX_W);
        end
    end

    // History shift register and fill level; a non-overlapping hit consumes its bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (data_edge) begin
            hist_q <= hist_n;
            fill_q <= (hit && !ovl_q) ? '0 : fill_n;
        end
    end

    // Registered one-cycle match pulse; hit already excludes load and idle edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
        end
    end

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (hit),
        .count (match_count)
    );

    assign armed = armed_q;
    assign match = match_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector with a small queue-based reference for a random run.
module tb_param_seq_detector;

    localparam int unsigned MAX_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LEN_W = $clog2(MAX_W + 1);

    logic             clk;
    logic             reset;
    logic             cfg_load;
    logic [MAX_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             din_valid;
    logic             din;
    logic             cnt_clr;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] match_count;

    int n_total;
    int n_bad;

    param_seq_detector #(
        .MAX_W (MAX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .cnt_clr     (cnt_clr),
        .armed       (armed),
        .match       (match),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_cfg(input logic [MAX_W-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl, input logic exp_armed, input string tag);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        check_eq({tag, ".armed"}, 32'(armed), 32'(exp_armed));
        check_eq({tag, ".match"}, 32'(match), 32'd0);
    endtask

    task automatic clear_cnt(input string tag);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_eq({tag, ".clr"}, 32'(match_count), 32'd0);
    endtask

    task automatic send(input logic b, input logic exp_m, input string tag);
        din_valid = 1'b1;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check_eq(tag, 32'(match), 32'(exp_m));
    endtask

    // Send n bits back-to-back, bit n-1 first; exp holds the expected match after each bit.
    task automatic send_seq(input logic [31:0] bits, input logic [31:0] exp, input int n,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], exp[i], $sformatf("%s[%0d]", tag, n - 1 - i));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s.idle%0d", tag, i), 32'(match), 32'd0);
        end
    endtask

    // Reference: queue of received bits, oldest first, trimmed to len.
    task automatic random_run(input logic [MAX_W-1:0] pat, input int len, input logic ovl,
                              input int cycles, input string tag);
        bit q[$];
        bit hit;
        bit v;
        bit b;
        int mcount;
        q.delete();
        mcount = 0;
        for (int c = 0; c < cycles; c++) begin
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            hit = 1'b0;
            if (v) begin
                q.push_back(b);
                if (q.size() > len) void'(q.pop_front());
                if (q.size() == len) begin
                    hit = 1'b1;
                    for (int k = 0; k < len; k++) begin
                        if (q[k] != pat[len-1-k]) hit = 1'b0;
                    end
                end
                if (hit && !ovl) q.delete();
                if (hit && mcount < 15) mcount++;
            end
            din_valid = v;
            din       = b;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            check_eq($sformatf("%s.m%0d", tag, c), 32'(match), 32'(hit));
        end
        check_eq({tag, ".count"}, 32'(match_count), 32'(mcount));
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        din_valid   = 1'b0;
        din         = 1'b0;
        cnt_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst.armed", 32'(armed), 32'd0);
        check_eq("rst.match", 32'(match), 32'd0);
        check_eq("rst.count", 32'(match_count), 32'd0);

        // Not armed before any load
        send_seq(32'b1010, 32'b0000, 4, "noload");

        // T1: overlapping 1010
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t1");
        send_seq(32'b101010, 32'b000101, 6, "t1");
        check_eq("t1.count", 32'(match_count), 32'd2);

        // T2: non-overlapping
        clear_cnt("t2");
        load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b1, "t2a");
        send_seq(32'b101010, 32'b000100, 6, "t2a");
        load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b1, "t2b");
        send_seq(32'b10101010, 32'b00010001, 8, "t2b");
        check_eq("t2.count", 32'(match_count), 32'd3);

        // T3: valid gaps
        clear_cnt("t3");
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t3");
        send_seq(32'b10, 32'b00, 2, "t3a");
        idle(3, "t3");
        send_seq(32'b10, 32'b01, 2, "t3b");
        check_eq("t3.count", 32'(match_count), 32'd1);

        // T4: reload clears history; illegal lengths disarm
        clear_cnt("t4");
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t4a");
        send_seq(32'b101, 32'b000, 3, "t4a");
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t4b");
        send_seq(32'b0, 32'b0, 1, "t4b");
        load_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, "t4len1");
        send_seq(32'b1111, 32'b0000, 4, "t4len1");
        load_cfg(8'b0000_1010, 4'd9, 1'b1, 1'b0, "t4len9");
        send_seq(32'b10101010, 32'b00000000, 8, "t4len9");
        check_eq("t4.count", 32'(match_count), 32'd0);

        // Length boundaries: full width, and len 2 with upper pattern bits masked
        load_cfg(8'hA5, 4'd8, 1'b1, 1'b1, "len8");
        send_seq(32'b110100101, 32'b000000001, 9, "len8");
        load_cfg(8'hF3, 4'd2, 1'b1, 1'b1, "len2o");
        send_seq(32'b111, 32'b011, 3, "len2o");
        load_cfg(8'hF3, 4'd2, 1'b0, 1'b1, "len2n");
        send_seq(32'b111, 32'b010, 3, "len2n");

        // T5: saturation at 15, then clear on a hit edge
        clear_cnt("t5");
        load_cfg(8'b0000_0011, 4'd2, 1'b1, 1'b1, "t5");
        send(1'b1, 1'b0, "t5.first");
        for (int i = 0; i < 17; i++) send(1'b1, 1'b1, $sformatf("t5.hit%0d", i));
        check_eq("t5.sat", 32'(match_count), 32'd15);
        cnt_clr = 1'b1;
        send(1'b1, 1'b1, "t5.clrhit");
        cnt_clr = 1'b0;
        check_eq("t5.clrcount", 32'(match_count), 32'd0);
        send(1'b1, 1'b1, "t5.after");
        check_eq("t5.aftercount", 32'(match_count), 32'd1);

        // T6: asynchronous reset between edges while match is high
        load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t6");
        send_seq(32'b1010, 32'b0001, 4, "t6");
        reset = 1'b1;
        #2;
        check_eq("t6.armed", 32'(armed), 32'd0);
        check_eq("t6.match", 32'(match), 32'd0);
        check_eq("t6.count", 32'(match_count), 32'd0);
        reset = 1'b0;
        send_seq(32'b101010, 32'b000000, 6, "t6post");

        // Random streams against the queue reference
        clear_cnt("rnd1");
        load_cfg(8'hFD, 4'd3, 1'b1, 1'b1, "rnd1");
        random_run(8'hFD, 3, 1'b1, 150, "rnd1");
        clear_cnt("rnd0");
        load_cfg(8'hFD, 4'd3, 1'b0, 1'b1, "rnd0");
        random_run(8'hFD, 3, 1'b0, 150, "rnd0");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
